// File: rtl/ts_rec_pkg.sv
// Shared definitions for the TS recorder datapath: status encoding and
// an elaboration-time ceil(log2) helper.
package ts_rec_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2,
        ST_ERROR  = 2'd3
    } fifo_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_ptr_wrap.sv
// Bit-address pointer over a store of CAP bits; advances by STEP and wraps
// with a compare-subtract because CAP is generally not a power of two.
module bit_ptr_wrap
    import ts_rec_pkg::*;
#(
    parameter int CAP   = 352,
    parameter int STEP  = 10,
    parameter int PTR_W = (clog2(CAP) < 1) ? 1 : clog2(CAP)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             advance,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W:0] sum;

    always_comb begin
        sum = {1'b0, ptr} + (PTR_W + 1)'(STEP);
    end

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (clear) begin
            ptr <= '0;
        end else if (advance) begin
            if (sum >= (PTR_W + 1)'(CAP)) begin
                ptr <= PTR_W'(sum - (PTR_W + 1)'(CAP));
            end else begin
                ptr <= PTR_W'(sum);
            end
        end
    end

endmodule

// File: rtl/bit_pack_fifo.sv
// Bit-packing FIFO: SYM_W-bit symbols packed back-to-back into a circular
// CAP-bit store, with level/status reporting, flush and a debug word port.
module bit_pack_fifo
    import ts_rec_pkg::*;
#(
    parameter int  SYM_W     = 10,
    parameter int  WORD_W    = 32,
    parameter int  DEPTH     = 11,
    parameter bit  MSB_FIRST = 1'b1,
    parameter int  LVL_W     = clog2(DEPTH * WORD_W + 1),
    localparam int SEL_W     = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH)
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              WRITE_IN,
    input  logic              READ_IN,
    input  logic              FLUSH,
    input  logic [SYM_W-1:0]  DATA_IN,
    output logic [SYM_W-1:0]  DATA_OUT,
    output logic              DATA_VALID,
    output logic [LVL_W-1:0]  LEVEL,
    output logic              FULL,
    output logic              EMPTY,
    output logic              OVERFLOW,
    output logic              UNDERFLOW,
    output logic [1:0]        STATE,
    input  logic [SEL_W-1:0]  DBG_SEL,
    output logic [WORD_W-1:0] DBG_WORD
);

    localparam int CAP   = DEPTH * WORD_W;
    localparam int PTR_W = (clog2(CAP) < 1) ? 1 : clog2(CAP);

    logic [CAP-1:0]   store;
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic             rd_ok;
    logic             wr_ok;
    logic             clear;
    logic [SYM_W-1:0] rd_sym;
    logic [LVL_W-1:0] level_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;
    fifo_state_e      state_q;

    // Bit address -> flat store index, honouring the in-word bit order.
    function automatic int flat_idx(input int addr);
        int pos;
        pos = addr % WORD_W;
        return (addr / WORD_W) * WORD_W + (MSB_FIRST ? (WORD_W - 1 - pos) : pos);
    endfunction

    function automatic int sym_bit(input int k);
        return MSB_FIRST ? (SYM_W - 1 - k) : k;
    endfunction

    function automatic int wrap_addr(input int addr);
        return (addr >= CAP) ? (addr - CAP) : addr;
    endfunction

    function automatic logic full_of(input logic [LVL_W-1:0] lvl);
        return (CAP - int'(lvl)) < SYM_W;
    endfunction

    function automatic logic empty_of(input logic [LVL_W-1:0] lvl);
        return int'(lvl) < SYM_W;
    endfunction

    // A full FIFO still takes a write when a read frees room in the same edge.
    assign rd_ok = READ_IN && !EMPTY;
    assign wr_ok = WRITE_IN && (!FULL || rd_ok);
    assign clear = RESET || FLUSH;
    assign STATE = state_q;

    bit_ptr_wrap #(.CAP(CAP), .STEP(SYM_W), .PTR_W(PTR_W)) u_wp (
        .clk     (CLOCK),
        .clear   (clear),
        .advance (wr_ok),
        .ptr     (wp)
    );

    bit_ptr_wrap #(.CAP(CAP), .STEP(SYM_W), .PTR_W(PTR_W)) u_rp (
        .clk     (CLOCK),
        .clear   (clear),
        .advance (rd_ok),
        .ptr     (rp)
    );

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_sym = '0;
        for (int k = 0; k < SYM_W; k++) begin
            rd_sym[sym_bit(k)] = store[flat_idx(wrap_addr(int'(rp) + k))];
        end
    end

    always_comb begin
        level_nxt = LEVEL;
        if (wr_ok && !rd_ok) begin
            level_nxt = LEVEL + LVL_W'(SYM_W);
        end else if (rd_ok && !wr_ok) begin
            level_nxt = LEVEL - LVL_W'(SYM_W);
        end
        ovf_nxt = OVERFLOW || (WRITE_IN && !wr_ok);
        unf_nxt = UNDERFLOW || (READ_IN && !rd_ok);
    end

    always_comb begin
        DBG_WORD = '0;
        if (int'(DBG_SEL) < DEPTH) begin
            DBG_WORD = store[int'(DBG_SEL) * WORD_W +: WORD_W];
        end
    end

    // NOTE: the store is a plain register array, so it can be (and is) cleared
    // on reset; flush leaves it untouched and only rewinds the pointers.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            store <= '0;
        end else if (!FLUSH && wr_ok) begin
            for (int a = 0; a < CAP; a++) begin
                int off;
                off = (a >= int'(wp)) ? (a - int'(wp)) : (a + CAP - int'(wp));
                if (off < SYM_W) begin
                    store[flat_idx(a)] <= DATA_IN[sym_bit(off)];
                end
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (clear) begin
            LEVEL      <= '0;
            FULL       <= 1'b0;
            EMPTY      <= 1'b1;
            OVERFLOW   <= 1'b0;
            UNDERFLOW  <= 1'b0;
            DATA_VALID <= 1'b0;
            state_q    <= ST_EMPTY;
            if (RESET) begin
                DATA_OUT <= '0;
            end
        end else begin
            LEVEL      <= level_nxt;
            FULL       <= full_of(level_nxt);
            EMPTY      <= empty_of(level_nxt);
            OVERFLOW   <= ovf_nxt;
            UNDERFLOW  <= unf_nxt;
            DATA_VALID <= rd_ok;
            if (rd_ok) begin
                DATA_OUT <= rd_sym;
            end
            if (ovf_nxt || unf_nxt) begin
                state_q <= ST_ERROR;
            end else if (full_of(level_nxt)) begin
                state_q <= ST_FULL;
            end else if (empty_of(level_nxt)) begin
                state_q <= ST_EMPTY;
            end else begin
                state_q <= ST_ACTIVE;
            end
        end
    end

endmodule

// File: tb/tb_bit_pack_fifo.sv
// Self-checking bench for bit_pack_fifo: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_bit_pack_fifo;

    localparam int SYM_W  = 10;
    localparam int WORD_W = 32;
    localparam int DEPTH  = 11;
    localparam int CAP    = DEPTH * WORD_W;
    localparam int NSYM   = CAP / SYM_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr;
    logic              rd;
    logic              fl;
    logic [SYM_W-1:0]  din;
    logic [SYM_W-1:0]  dout;
    logic              dvalid;
    logic [8:0]        level;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              unf;
    logic [1:0]        state;
    logic [3:0]        dbg_sel;
    logic [WORD_W-1:0] dbg_word;

    always #5 clk = ~clk;

    bit_pack_fifo #(
        .SYM_W    (SYM_W),
        .WORD_W   (WORD_W),
        .DEPTH    (DEPTH),
        .MSB_FIRST(1'b1)
    ) dut (
        .CLOCK     (clk),
        .RESET     (rst),
        .WRITE_IN  (wr),
        .READ_IN   (rd),
        .FLUSH     (fl),
        .DATA_IN   (din),
        .DATA_OUT  (dout),
        .DATA_VALID(dvalid),
        .LEVEL     (level),
        .FULL      (full),
        .EMPTY     (empty),
        .OVERFLOW  (ovf),
        .UNDERFLOW (unf),
        .STATE     (state),
        .DBG_SEL   (dbg_sel),
        .DBG_WORD  (dbg_word)
    );

    // Reference model: symbol queue plus a bit-addressed image of the store.
    logic [SYM_W-1:0] m_q[$];
    bit               m_bits[CAP];
    int               m_wp;
    bit               m_ovf;
    bit               m_unf;
    bit               m_valid;
    logic [SYM_W-1:0] m_out;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WORD_W-1:0] m_word(input int w);
        logic [WORD_W-1:0] r;
        r = '0;
        if (w < DEPTH) begin
            for (int i = 0; i < WORD_W; i++) begin
                r[WORD_W-1-i] = m_bits[w * WORD_W + i];
            end
        end
        return r;
    endfunction

    task automatic model_edge(input bit r, input bit w, input bit rdd, input bit f,
                              input logic [SYM_W-1:0] d);
        bit rd_acc;
        bit wr_acc;
        if (r) begin
            m_q.delete();
            foreach (m_bits[i]) m_bits[i] = 1'b0;
            m_wp = 0; m_ovf = 0; m_unf = 0; m_valid = 0; m_out = '0;
        end else if (f) begin
            m_q.delete();
            m_wp = 0; m_ovf = 0; m_unf = 0; m_valid = 0;
        end else begin
            rd_acc = rdd && (m_q.size() > 0);
            wr_acc = w && ((m_q.size() < NSYM) || rd_acc);
            if (rdd && !rd_acc) m_unf = 1;
            if (w && !wr_acc) m_ovf = 1;
            m_valid = rd_acc;
            if (rd_acc) m_out = m_q.pop_front();
            if (wr_acc) begin
                m_q.push_back(d);
                for (int k = 0; k < SYM_W; k++) begin
                    m_bits[(m_wp + k) % CAP] = d[SYM_W-1-k];
                end
                m_wp = (m_wp + SYM_W) % CAP;
            end
        end
    endtask

    task automatic compare_all();
        int lvl;
        int sel;
        int exp_state;
        lvl = m_q.size() * SYM_W;
        if (m_ovf || m_unf)          exp_state = 3;
        else if (CAP - lvl < SYM_W)  exp_state = 2;
        else if (lvl < SYM_W)        exp_state = 0;
        else                         exp_state = 1;
        check("level", 64'(level), 64'(lvl));
        check("full", 64'(full), 64'(CAP - lvl < SYM_W));
        check("empty", 64'(empty), 64'(lvl < SYM_W));
        check("overflow", 64'(ovf), 64'(m_ovf));
        check("underflow", 64'(unf), 64'(m_unf));
        check("state", 64'(state), 64'(exp_state));
        check("data_valid", 64'(dvalid), 64'(m_valid));
        check("data_out", 64'(dout), 64'(m_out));
        sel = $urandom_range(0, 15);
        dbg_sel = 4'(sel);
        #1;
        check("dbg_word", 64'(dbg_word), 64'(m_word(sel)));
    endtask

    task automatic cycle(input bit r, input bit w, input bit rdd, input bit f,
                         input logic [SYM_W-1:0] d);
        rst = r; wr = w; rd = rdd; fl = f; din = d;
        @(posedge clk);
        #1;
        model_edge(r, w, rdd, f, d);
        rst = 1'b0; wr = 1'b0; rd = 1'b0; fl = 1'b0;
        compare_all();
    endtask

    task automatic dbg_check(input string tag, input int sel, input logic [WORD_W-1:0] exp);
        dbg_sel = 4'(sel);
        #1;
        check(tag, 64'(dbg_word), 64'(exp));
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0, '0);
        cycle(1, 0, 0, 0, '0);
    endtask

    initial begin
        int p_wr;
        int p_rd;
        logic [SYM_W-1:0] d;
        rst = 1'b0; wr = 1'b0; rd = 1'b0; fl = 1'b0; din = '0; dbg_sel = '0;
        m_wp = 0; m_ovf = 0; m_unf = 0; m_valid = 0; m_out = '0;
        @(negedge clk);

        // Reset and single symbol
        do_reset();
        check("rst_state", 64'(state), 64'(0));
        check("rst_empty", 64'(empty), 64'(1));
        dbg_check("rst_word0", 0, 32'h0);
        cycle(0, 1, 0, 0, 10'h200);
        dbg_check("single_word0", 0, 32'h8000_0000);
        check("single_level_w", 64'(level), 64'(10));
        cycle(0, 0, 1, 0, '0);
        check("single_dout", 64'(dout), 64'(10'h200));
        check("single_valid", 64'(dvalid), 64'(1));
        check("single_level_r", 64'(level), 64'(0));
        cycle(0, 0, 0, 0, '0);
        check("single_valid_drop", 64'(dvalid), 64'(0));

        // Packing across a word boundary
        do_reset();
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 10'h3FF);
        dbg_check("pack_word0", 0, 32'hFFFF_FFFF);
        dbg_check("pack_word1", 1, 32'hFF00_0000);
        check("pack_level", 64'(level), 64'(40));

        // Full and overflow
        do_reset();
        for (int i = 0; i < NSYM; i++) cycle(0, 1, 0, 0, 10'(10'h100 + i));
        check("full_flag", 64'(full), 64'(1));
        check("full_level", 64'(level), 64'(350));
        check("full_state", 64'(state), 64'(2));
        cycle(0, 1, 0, 0, 10'h3AB);
        check("ovf_flag", 64'(ovf), 64'(1));
        check("ovf_state", 64'(state), 64'(3));
        check("ovf_level", 64'(level), 64'(350));
        for (int i = 0; i < NSYM; i++) begin
            cycle(0, 0, 1, 0, '0);
            check("full_readback", 64'(dout), 64'(10'h100 + i));
        end

        // Wrap-around
        do_reset();
        for (int i = 0; i < NSYM; i++) cycle(0, 1, 0, 0, 10'($urandom));
        for (int i = 0; i < NSYM; i++) cycle(0, 0, 1, 0, '0);
        cycle(0, 1, 0, 0, 10'h2AA);
        dbg_sel = 4'd10;
        #1;
        check("wrap_word10_tail", 64'(dbg_word[1:0]), 64'(2'b10));
        dbg_sel = 4'd0;
        #1;
        check("wrap_word0_head", 64'(dbg_word[31:24]), 64'(8'hAA));
        cycle(0, 0, 1, 0, '0);
        check("wrap_dout", 64'(dout), 64'(10'h2AA));

        // Simultaneous strobes: empty, then full
        do_reset();
        cycle(0, 1, 1, 0, 10'h155);
        check("sim_empty_unf", 64'(unf), 64'(1));
        check("sim_empty_level", 64'(level), 64'(10));
        do_reset();
        for (int i = 0; i < NSYM; i++) cycle(0, 1, 0, 0, 10'(10'h040 + i));
        cycle(0, 1, 1, 0, 10'h0F0);
        check("sim_full_level", 64'(level), 64'(350));
        check("sim_full_ovf", 64'(ovf), 64'(0));
        check("sim_full_dout", 64'(dout), 64'(10'h040));

        // Flush mid-stream
        do_reset();
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 10'(10'h011 * (i + 1)));
        cycle(0, 1, 0, 1, 10'h3C3);
        check("flush_level", 64'(level), 64'(0));
        check("flush_empty", 64'(empty), 64'(1));
        check("flush_flags", 64'({ovf, unf}), 64'(0));
        cycle(0, 1, 0, 0, 10'h1E5);
        cycle(0, 0, 1, 0, '0);
        check("flush_newsym", 64'(dout), 64'(10'h1E5));

        // Randomized traffic with varying write/read pressure
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            p_wr = (ph == 0) ? 75 : (ph == 1) ? 50 : (ph == 2) ? 25 : 55;
            p_rd = 100 - p_wr;
            for (int n = 0; n < 600; n++) begin
                d = 10'($urandom);
                cycle(($urandom_range(0, 699) == 0),
                      ($urandom_range(0, 99) < p_wr),
                      ($urandom_range(0, 99) < p_rd),
                      ($urandom_range(0, 149) == 0),
                      d);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_pack_fifo.md
# bit_pack_fifo

Parametrised bit-packing FIFO for the TS recorder datapath. Symbols of SYM_W bits are packed back-to-back, with no padding, into a circular store of DEPTH words of WORD_W bits. Symbols are read out in arrival order, and a symbol may straddle a word boundary and the wrap point. It generalises the fixed 10-bit/32-bit, 11-word packing buffer: symbol width, word width, depth and bit order are configurable, and it adds level/full/empty reporting, flush, sticky error flags and a debug word port.

## Interface
- SYM_W, 10, symbol width in bits; 1 ≤ SYM_W ≤ WORD_W
- WORD_W, 32, storage word width
- DEPTH, 11, number of storage words; CAP = DEPTH*WORD_W ≥ SYM_W
- MSB_FIRST, 1, 1: symbol MSB at lowest bit address, word MSB is lowest address; 0: LSB order throughout
- LVL_W, $clog2(CAP+1), width of LEVEL (derived)

Ports:
- CLOCK  in  1  sole clock, rising edge
- RESET  in  1  synchronous, active-high
- WRITE_IN  in  1  push-symbol strobe
- READ_IN  in  1  pop-symbol strobe
- FLUSH  in  1  synchronous clear of pointers, level and error flags; store contents are kept
- DATA_IN  in  SYM_W  symbol to push
- DATA_OUT  out  SYM_W  popped symbol, registered
- DATA_VALID  out  1  one-cycle pulse, DATA_OUT updated
- LEVEL  out  LVL_W  stored bits
- FULL  out  1  CAP−LEVEL < SYM_W
- EMPTY  out  1  LEVEL < SYM_W
- OVERFLOW  out  1  sticky, write rejected
- UNDERFLOW  out  1  sticky, read rejected
- STATE  out  2  0 EMPTY, 1 ACTIVE, 2 FULL, 3 ERROR
- DBG_SEL  in  $clog2(DEPTH)  word select
- DBG_WORD  out  WORD_W  combinational view of store word DBG_SEL; 0 if DBG_SEL ≥ DEPTH

## Operation
- The store is CAP bits at bit addresses 0..CAP−1. Word index = addr / WORD_W.
- Bit position within a word: WORD_W−1−(addr mod WORD_W) when MSB_FIRST, else addr mod WORD_W.
- Write pointer WP and read pointer RP are bit addresses. Each advances by SYM_W modulo CAP, using an explicit compare-subtract wrap because CAP is not a power of two.
- Write: symbol bit k goes to address WP+k (mod CAP). When MSB_FIRST, k counts from the symbol MSB; otherwise from the LSB.
- Acceptance is judged on pre-edge state:
  - Read is accepted iff !EMPTY.
  - Write is accepted iff !FULL, or FULL with a simultaneous accepted read.
- A rejected write sets OVERFLOW and changes nothing else.
- A rejected read sets UNDERFLOW, holds DATA_OUT and keeps DATA_VALID low.
- Simultaneous accepted read and write: the read returns the oldest stored symbol, never the one being written. LEVEL is unchanged.
- LEVEL updates: +SYM_W per accepted write, −SYM_W per accepted read.
- STATE priority: ERROR if OVERFLOW|UNDERFLOW; else FULL; else EMPTY; else ACTIVE.
- FLUSH clears WP, RP, LEVEL, OVERFLOW and UNDERFLOW, with the same priority as RESET. Strobes in the same cycle are ignored.
- RESET additionally zeroes the store and DATA_OUT. A reset mid-operation discards all content.

## Timing
- Reset values: DATA_OUT 0, DATA_VALID 0, LEVEL 0, FULL 0, EMPTY 1, OVERFLOW 0, UNDERFLOW 0, STATE 0. The store is 0, so DBG_WORD reads 0.
- Strobes are sampled on the rising edge. Strobes are level-sensitive: a strobe held high for N cycles performs N operations.
- LEVEL, FULL, EMPTY and STATE reflect an operation one cycle after its strobe edge (all registered).
- Read latency is 1: DATA_OUT and DATA_VALID are valid in the cycle after the accepted READ_IN edge.
- DBG_WORD reflects a write in the cycle after the WRITE_IN edge.
- Error flags assert in the cycle after the offending strobe and stay set until RESET or FLUSH.

## Structure
- The shared package ts_rec_pkg holds:
  - the STATE encoding constants ST_EMPTY, ST_ACTIVE, ST_FULL, ST_ERROR
  - a clog2 helper
- One sub-module, bit_ptr_wrap, is natural: a CAP-modulo pointer with an advance-by-SYM_W input and registered output. It is instantiated twice, for WP and RP.
- Store and bit mapping live in bit_pack_fifo as a flat CAP-bit register, written via a per-bit address decode.

## Test plan
All scenarios use defaults: CAP = 352, 35 symbols fit.
- **Reset and single symbol.** Reset, write 10'h200, read.
  - After the write: DBG_SEL=0 gives 32'h8000_0000.
  - After the read: DATA_OUT=10'h200, DATA_VALID pulses, LEVEL 10 → 0.
- **Packing across a boundary.** Write 10'h3FF four times.
  - Word0 = 32'hFFFF_FFFF, word1 = 32'hFF00_0000, LEVEL = 40.
- **Full and overflow.** Write 35 distinct symbols.
  - FULL=1, LEVEL=350, STATE=2.
  - A 36th write sets OVERFLOW, STATE=3, LEVEL stays 350.
  - Reading all 35 returns them in order. The rejected symbol never appears.
- **Wrap-around.** Run 35 writes and 35 reads, so WP = RP = 350, then write 10'h2AA and read it.
  - Bits 350 and 351 of word10 hold "10"; word0 bits [31:24] hold 8'hAA.
  - DATA_OUT = 10'h2AA.
- **Simultaneous strobes.**
  - Empty with read+write in one cycle: UNDERFLOW=1, write accepted, LEVEL = 10.
  - Full with read+write in one cycle: both accepted, LEVEL stays 350, no OVERFLOW.
- **Flush mid-stream.** Write 5 symbols, then FLUSH together with WRITE_IN.
  - LEVEL=0, EMPTY=1, flags clear, the write is ignored.
  - The next write-then-read returns the new symbol.
